uart_tx_frame: RTL and testbench

Parametrised UART transmitter: the next-generation serial TX for the UART physical layer. It accepts parallel words over a valid/ready handshake and serialises each word LSB-first with a start bit, an optional parity bit and one or two stop bits. Data width is set at build time; baud divisor, parity mode and stop-bit count are set at run time. It replaces the fixed 8-bit, fixed-parity, fixed-baud transmitter and sits between the host-side data source and the `tx` line.

---
 rtl/uart_tx_frame.sv | 134 +++++++++++++
 tb/tb_uart_tx_frame.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises parallel words LSB-first with start bit, optional
// even/odd parity and one or two stop bits; baud divisor and framing latched per word.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_two,
    output logic                  tx,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            pmode_q;
    logic                  stop_two_q;
    logic                  tx_q;

    logic bit_end;
    logic parity_en;
    logic parity_bit;

    // div_q never holds 0 (clamped at accept), so div_q - 1 cannot underflow.
    assign bit_end    = (cnt == div_q - DIV_WIDTH'(1));
    assign parity_en  = pmode_q[0] ^ pmode_q[1];
    assign parity_bit = (^data_q) ^ pmode_q[1];
    assign next_idx   = idx + IDX_W'(1);

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign tx       = tx_q;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the tx level is registered alongside its state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            div_q      <= DIV_WIDTH'(1);
            idx        <= '0;
            stop_cnt   <= 1'b0;
            data_q     <= '0;
            pmode_q    <= 2'b00;
            stop_two_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end

            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_valid) begin
                        data_q     <= data_in;
                        div_q      <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
                        pmode_q    <= parity_mode;
                        stop_two_q <= stop_two;
                        state      <= START;
                        tx_q       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                        tx_q  <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx < LAST_IDX) begin
                            idx  <= next_idx;
                            tx_q <= data_q[next_idx];
                        end else if (parity_en) begin
                            state <= PARITY;
                            tx_q  <= parity_bit;
                        end else begin
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            tx_q     <= 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx_q     <= 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        if (stop_two_q && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of framed words with hand-computed line
// patterns, plus back-to-back, mid-frame config change and reset-abort sequences.
module tb_uart_tx_frame;

    logic        clock;
    logic        reset;
    logic [7:0]  data_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop_two;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop_two    (stop_two),
        .tx          (tx),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  pmode;
        logic        stop2;
        logic [12:0] frame;  // line levels in transmission order, bit 0 first
        int          nbits;
        int          len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic accept_word(input logic [7:0] d, input logic [15:0] dv,
                               input logic [1:0] pm, input logic st, input bit hold);
        int waited;
        @(negedge clock);
        data_in     = d;
        baud_div    = dv;
        parity_mode = pm;
        stop_two    = st;
        tx_valid    = 1'b1;
        waited = 0;
        while (!tx_ready && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        if (!tx_ready) check("accept_wait_ready", 0, 1);
        @(posedge clock);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Samples tx on each falling edge while busy; counts cycles that differ from the frame.
    task automatic capture(input string name, input logic [12:0] frame, input int nbits,
                           input int div_eff, input int len, input bit chg, input bit drop);
        int c;
        int bad;
        int bi;
        logic exp_bit;
        c = 0;
        bad = 0;
        while (c < 2000) begin
            @(negedge clock);
            if (drop) tx_valid = 1'b0;
            if (chg && c == 12) begin
                baud_div    = 16'd9;
                parity_mode = 2'b01;
            end
            if (!busy) break;
            bi = c / div_eff;
            exp_bit = (bi < nbits) ? frame[bi] : 1'b1;
            if (tx !== exp_bit) bad++;
            c++;
        end
        check({name, "_wave_bad_cycles"}, bad, 0);
        check({name, "_busy_cycles"}, c, len);
        check({name, "_ready_after"}, int'(tx_ready), 1);
        check({name, "_tx_idle_after"}, int'(tx), 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 16'd4, 2'b00, 1'b0, 13'({1'b1, 8'hA5, 1'b0}), 10, 40};
        vecs[1] = '{8'h07, 16'd3, 2'b01, 1'b0, 13'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 33};
        vecs[2] = '{8'h03, 16'd3, 2'b01, 1'b0, 13'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 33};
        vecs[3] = '{8'h03, 16'd2, 2'b10, 1'b1, 13'({1'b1, 1'b1, 1'b1, 8'h03, 1'b0}), 12, 24};
        vecs[4] = '{8'h3C, 16'd0, 2'b00, 1'b0, 13'({1'b1, 8'h3C, 1'b0}), 10, 10};
        vecs[5] = '{8'h81, 16'd1, 2'b11, 1'b0, 13'({1'b1, 8'h81, 1'b0}), 10, 10};
        vecs[6] = '{8'h00, 16'd2, 2'b10, 1'b0, 13'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 22};
        vecs[7] = '{8'h5A, 16'd3, 2'b00, 1'b1, 13'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, 33};

        reset       = 1'b0;
        data_in     = '0;
        tx_valid    = 1'b0;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop_two    = 1'b0;
        #12;
        check("reset_tx", int'(tx), 1);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            accept_word(vecs[i].data, vecs[i].div, vecs[i].pmode, vecs[i].stop2, 1'b0);
            capture($sformatf("vec%0d", i), vecs[i].frame, vecs[i].nbits,
                    (vecs[i].div == 16'd0) ? 1 : int'(vecs[i].div), vecs[i].len, 1'b0, 1'b0);
        end

        // Config change during DATA must not affect the frame in flight.
        accept_word(8'hA5, 16'd4, 2'b00, 1'b0, 1'b0);
        capture("midcfg_cur", 13'({1'b1, 8'hA5, 1'b0}), 10, 4, 40, 1'b1, 1'b0);
        accept_word(8'h01, baud_div, parity_mode, stop_two, 1'b0);
        capture("midcfg_next", 13'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 9, 99, 1'b0, 1'b0);

        // Back-to-back with tx_valid held: one idle cycle between frames.
        accept_word(8'h12, 16'd2, 2'b00, 1'b0, 1'b1);
        data_in = 8'h34;
        capture("b2b_first", 13'({1'b1, 8'h12, 1'b0}), 10, 2, 20, 1'b0, 1'b0);
        capture("b2b_second", 13'({1'b1, 8'h34, 1'b0}), 10, 2, 20, 1'b0, 1'b1);

        // Reset mid-DATA with a zero word so tx is low when the abort lands.
        accept_word(8'h00, 16'd4, 2'b00, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        check("abort_tx_low_before", int'(tx), 0);
        #2;
        reset = 1'b0;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_ready", int'(tx_ready), 1);
        check("abort_busy", int'(busy), 0);
        tx_valid = 1'b1;
        @(posedge clock);
        #1;
        check("reset_ignores_valid", int'(busy), 0);
        tx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        accept_word(8'hA5, 16'd2, 2'b00, 1'b0, 1'b0);
        capture("post_abort", 13'({1'b1, 8'hA5, 1'b0}), 10, 2, 20, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
